// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin-return transmitter (quarter/dime/nickle pulses).
// Optional feature macro COIN_INVENTORY_EN adds finite coin stock and restock.
module change_dispenser #(
  parameter int AMT_W      = 6,
  parameter int GAP_CYCLES = 1
`ifdef COIN_INVENTORY_EN
  ,
  parameter int INV_W      = 4,
  parameter int INV_INIT   = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change_amt,
`ifdef COIN_INVENTORY_EN
  input  logic             restock,
`endif
  output logic             change_ready,
  output logic             nickle_out,
  output logic             dime_out,
  output logic             quarter_out,
  output logic             done,
  output logic             short
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DISP = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int GW =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [AMT_W-1:0] V25 = AMT_W'(25);
  localparam logic [AMT_W-1:0] V10 = AMT_W'(10);
  localparam logic [AMT_W-1:0] V5  = AMT_W'(5);

  logic [1:0]       state;
  logic [AMT_W-1:0] rem;
  logic [GW-1:0]    gap_cnt;

  logic ok_q, ok_d, ok_n;
  logic take_q, take_d, take_n;
  logic any_ok;
  logic [AMT_W-1:0] coin_val;

`ifdef COIN_INVENTORY_EN
  localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INV_INIT);
  logic [INV_W-1:0] inv_q, inv_d, inv_n;
`endif

  // Threshold is checked before any subtract, so rem never wraps.
  always_comb begin
    ok_q = (rem >= V25);
    ok_d = (rem >= V10);
    ok_n = (rem >= V5);
`ifdef COIN_INVENTORY_EN
    ok_q = ok_q && (inv_q != '0);
    ok_d = ok_d && (inv_d != '0);
    ok_n = ok_n && (inv_n != '0);
`endif
    take_q = ok_q;
    take_d = !ok_q && ok_d;
    take_n = !ok_q && !ok_d && ok_n;
    any_ok = ok_q || ok_d || ok_n;
    coin_val = take_q ? V25 : (take_d ? V10 : V5);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      rem          <= '0;
      gap_cnt      <= '0;
      change_ready <= 1'b1;
      nickle_out   <= 1'b0;
      dime_out     <= 1'b0;
      quarter_out  <= 1'b0;
      done         <= 1'b0;
      short        <= 1'b0;
`ifdef COIN_INVENTORY_EN
      inv_q        <= INV_LOAD;
      inv_d        <= INV_LOAD;
      inv_n        <= INV_LOAD;
`endif
    end else begin
      nickle_out  <= 1'b0;
      dime_out    <= 1'b0;
      quarter_out <= 1'b0;
      done        <= 1'b0;
      short       <= 1'b0;
      case (state)
        IDLE: begin
`ifdef COIN_INVENTORY_EN
          if (restock) begin
            inv_q <= INV_LOAD;
            inv_d <= INV_LOAD;
            inv_n <= INV_LOAD;
          end
`endif
          if (change_valid) begin
            rem          <= change_amt;
            change_ready <= 1'b0;
            state        <= DISP;
          end
        end
        DISP: begin
          if (any_ok) begin
            quarter_out <= take_q;
            dime_out    <= take_d;
            nickle_out  <= take_n;
            rem         <= rem - coin_val;
            gap_cnt     <= GAP_LAST;
            state       <= (GAP_CYCLES == 0) ? DISP : GAP;
`ifdef COIN_INVENTORY_EN
            if (take_q) inv_q <= inv_q - 1'b1;
            if (take_d) inv_d <= inv_d - 1'b1;
            if (take_n) inv_n <= inv_n - 1'b1;
`endif
          end else begin
            done  <= 1'b1;
            short <= (rem != '0);
            state <= DONE;
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= DISP;
          else gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
          change_ready <= 1'b1;
          rem          <= '0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
